// File: rtl/fp32_div_unpack_if.sv
// Operand, divider-issue and side-band signals of the FP32 divide front end.
// slave: the unpack stage itself; master: whatever drives operands and
// consumes the divider issue and side-band.
interface fp32_div_unpack_if;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] a;
    logic [31:0] b;
    logic        div_vld;
    logic [47:0] div_ain;
    logic [23:0] div_bin;
    logic        sb_vld;
    logic        sb_sign;
    logic [9:0]  sb_exp;
    logic [1:0]  sb_cls;
    logic        sb_dz;

    modport master (
        output in_vld, a, b,
        input  in_rdy, div_vld, div_ain, div_bin,
        input  sb_vld, sb_sign, sb_exp, sb_cls, sb_dz
    );

    modport slave (
        input  in_vld, a, b,
        output in_rdy, div_vld, div_ain, div_bin,
        output sb_vld, sb_sign, sb_exp, sb_cls, sb_dz
    );
endinterface

// File: rtl/fp32_div_unpack.sv
// FP32 divide front end: unpacks and classifies two operands, issues the
// mantissas to the 48/24 divider and delays the sign/exponent/class
// side-band by DIV_LAT+1 stages so it lines up with the divider quotient.
// Macro FP_DIV_SUBNORM_EN: when defined, subnormal operands are normalized
// in a NORM state (one bit per cycle); when undefined, subnormals are
// treated as zero and every accepted pair issues on the accept edge.
module fp32_div_unpack #(
    parameter int DIV_LAT  = 5,
    parameter int EXP_BIAS = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    fp32_div_unpack_if.slave io
);
    localparam logic [1:0] CLS_NORMAL = 2'd0;
    localparam logic [1:0] CLS_ZERO   = 2'd1;
    localparam logic [1:0] CLS_INF    = 2'd2;
    localparam logic [1:0] CLS_NAN    = 2'd3;

    typedef struct packed {
        logic [23:0] mant;
        logic [9:0]  exp;
        logic        zero;
        logic        inf;
        logic        nan;
    } op_t;

    typedef struct packed {
        logic       sign;
        logic [9:0] exp;
        logic [1:0] cls;
        logic       dz;
    } sb_t;

    // Field split of one operand (sign handled separately).
    function automatic op_t unpack(input logic [30:0] x);
        op_t o;
        o.mant = {1'b1, x[22:0]};
        o.exp  = {2'b00, x[30:23]};
        o.zero = 1'b0;
        o.inf  = 1'b0;
        o.nan  = 1'b0;
        if (x[30:23] == 8'd0) begin
            if (x[22:0] == 23'd0) begin
                o.zero = 1'b1;
            end else begin
`ifdef FP_DIV_SUBNORM_EN
                o.mant = {1'b0, x[22:0]};
                o.exp  = 10'd1;
`else
                o.zero = 1'b1;
`endif
            end
        end else if (x[30:23] == 8'hFF) begin
            o.inf = (x[22:0] == 23'd0);
            o.nan = (x[22:0] != 23'd0);
        end
        return o;
    endfunction

    op_t         ua, ub;
    logic [1:0]  cls;
    logic        dz;
    logic        sgn;
    logic [9:0]  exp_diff;
    logic [47:0] d_ain;
    logic [23:0] d_bin;
    sb_t         d_sb;

    logic                div_vld_q;
    logic [47:0]         div_ain_q;
    logic [23:0]         div_bin_q;
    logic [DIV_LAT:0]    vld_pipe;
    sb_t  [DIV_LAT:0]    sb_pipe;

    // Classify the incoming pair and form the direct-issue payload.
    always_comb begin
        ua       = unpack(io.a[30:0]);
        ub       = unpack(io.b[30:0]);
        sgn      = io.a[31] ^ io.b[31];
        dz       = 1'b0;
        if (ua.nan || ub.nan || (ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
            cls = CLS_NAN;
        end else if (ua.inf || ub.zero) begin
            cls = CLS_INF;
            dz  = ub.zero && !ua.zero && !ua.inf;
        end else if (ua.zero || ub.inf) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORMAL;
        end
        exp_diff = ua.exp - ub.exp + 10'(EXP_BIAS);
        // Specials send a harmless 0/1.0 through the divider to keep alignment.
        d_ain    = (cls == CLS_NORMAL) ? {ua.mant, 24'h0} : 48'h0;
        d_bin    = (cls == CLS_NORMAL) ? ub.mant : 24'h800000;
        d_sb     = '{sign: sgn, exp: exp_diff, cls: cls, dz: dz};
    end

`ifdef FP_DIV_SUBNORM_EN
    typedef enum logic {IDLE, NORM} state_t;

    state_t      state;
    logic [23:0] ma, mb;
    logic [9:0]  ea, eb;
    logic        ws;
    logic        need_norm;
    logic [9:0]  norm_exp;

    // Only NORMAL-class pairs need normalizing; specials issue directly.
    assign need_norm   = (cls == CLS_NORMAL) && !(ua.mant[23] && ub.mant[23]);
    assign norm_exp    = ea - eb + 10'(EXP_BIAS);
    assign io.in_rdy   = en && (state == IDLE);
`else
    assign io.in_rdy   = en;
`endif

    // Issue FSM, divider operand registers and side-band delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_vld_q <= 1'b0;
            div_ain_q <= '0;
            div_bin_q <= '0;
            vld_pipe  <= '0;
            sb_pipe   <= '0;
`ifdef FP_DIV_SUBNORM_EN
            state     <= IDLE;
            ma        <= '0;
            mb        <= '0;
            ea        <= '0;
            eb        <= '0;
            ws        <= 1'b0;
`endif
        end else if (en) begin
            div_vld_q   <= 1'b0;
            vld_pipe[0] <= 1'b0;
            for (int i = 1; i <= DIV_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sb_pipe[i]  <= sb_pipe[i-1];
            end
`ifdef FP_DIV_SUBNORM_EN
            case (state)
                IDLE: begin
                    if (io.in_vld) begin
                        if (need_norm) begin
                            ma    <= ua.mant;
                            mb    <= ub.mant;
                            ea    <= ua.exp;
                            eb    <= ub.exp;
                            ws    <= sgn;
                            state <= NORM;
                        end else begin
                            div_vld_q   <= 1'b1;
                            div_ain_q   <= d_ain;
                            div_bin_q   <= d_bin;
                            vld_pipe[0] <= 1'b1;
                            sb_pipe[0]  <= d_sb;
                        end
                    end
                end
                NORM: begin
                    if (ma[23] && mb[23]) begin
                        div_vld_q   <= 1'b1;
                        div_ain_q   <= {ma, 24'h0};
                        div_bin_q   <= mb;
                        vld_pipe[0] <= 1'b1;
                        sb_pipe[0]  <= '{sign: ws, exp: norm_exp, cls: CLS_NORMAL, dz: 1'b0};
                        state       <= IDLE;
                    end else begin
                        if (!ma[23]) begin
                            ma <= ma << 1;
                            ea <= ea - 10'd1;
                        end
                        if (!mb[23]) begin
                            mb <= mb << 1;
                            eb <= eb - 10'd1;
                        end
                    end
                end
            endcase
`else
            if (io.in_vld) begin
                div_vld_q   <= 1'b1;
                div_ain_q   <= d_ain;
                div_bin_q   <= d_bin;
                vld_pipe[0] <= 1'b1;
                sb_pipe[0]  <= d_sb;
            end
`endif
        end
    end

    assign io.div_vld = div_vld_q;
    assign io.div_ain = div_ain_q;
    assign io.div_bin = div_bin_q;
    assign io.sb_vld  = vld_pipe[DIV_LAT];
    assign io.sb_sign = sb_pipe[DIV_LAT].sign;
    assign io.sb_exp  = sb_pipe[DIV_LAT].exp;
    assign io.sb_cls  = sb_pipe[DIV_LAT].cls;
    assign io.sb_dz   = sb_pipe[DIV_LAT].dz;

endmodule

// File: tb/tb_fp32_div_unpack.sv
// Scoreboard bench for fp32_div_unpack: the driver pushes expected divider
// issues and side-band words (with the en-edge they must appear on); a
// monitor pops and compares whenever div_vld / sb_vld is presented.
module tb_fp32_div_unpack;
    localparam int DIV_LAT = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    fp32_div_unpack_if io();

    fp32_div_unpack #(.DIV_LAT(DIV_LAT), .EXP_BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .io    (io)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] ain;
        logic [23:0] bin;
        logic        sign;
        logic [9:0]  exp;
        logic [1:0]  cls;
        logic        dz;
        int          off;
        int          edge_n;
    } exp_t;

    exp_t issue_q[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_edges = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [95:0] outs();
        return 96'({io.div_vld, io.div_ain, io.div_bin, io.sb_vld, io.sb_sign,
                    io.sb_exp, io.sb_cls, io.sb_dz});
    endfunction

    function automatic exp_t mk(input logic [47:0] ain, input logic [23:0] bin,
                                input logic sign, input logic [9:0] ex,
                                input logic [1:0] cls, input logic dz, input int off);
        exp_t e;
        e.ain = ain; e.bin = bin; e.sign = sign; e.exp = ex;
        e.cls = cls; e.dz = dz; e.off = off; e.edge_n = 0;
        return e;
    endfunction

    // Reference: IEEE classification, leading-one normalization by loop,
    // latency = 0 extra edges if no shifting, else shifts + 1.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [7:0]  ex, ey;
        logic [22:0] fx, fy;
        bit          xz, xi, xn, yz, yi, yn;
        logic [23:0] mx, my;
        int          px, py, sx, sy, sm;
        ex = x[30:23]; fx = x[22:0];
        ey = y[30:23]; fy = y[22:0];
        xi = (ex == 8'hFF) && (fx == 0);
        xn = (ex == 8'hFF) && (fx != 0);
        yi = (ey == 8'hFF) && (fy == 0);
        yn = (ey == 8'hFF) && (fy != 0);
`ifdef FP_DIV_SUBNORM_EN
        xz = (ex == 0) && (fx == 0);
        yz = (ey == 0) && (fy == 0);
`else
        xz = (ex == 0);
        yz = (ey == 0);
`endif
        e = mk(48'h0, 24'h800000, x[31] ^ y[31], 10'd0, 2'd0, 1'b0, 0);
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            e.cls = 2'd3;
        end else if (xi || yz) begin
            e.cls = 2'd2;
            e.dz  = yz && !xz && !xi;
        end else if (xz || yi) begin
            e.cls = 2'd1;
        end else begin
            mx = (ex == 0) ? {1'b0, fx} : {1'b1, fx};
            my = (ey == 0) ? {1'b0, fy} : {1'b1, fy};
            px = (ex == 0) ? 1 : int'(ex);
            py = (ey == 0) ? 1 : int'(ey);
            sx = 0; sy = 0;
            while (mx[23] == 1'b0) begin mx = mx << 1; px--; sx++; end
            while (my[23] == 1'b0) begin my = my << 1; py--; sy++; end
            sm = (sx > sy) ? sx : sy;
            e.ain = {mx, 24'h0};
            e.bin = my;
            e.exp = 10'(px - py + 127);
            e.off = (sm == 0) ? 0 : sm + 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:       r[30:0] = 31'h0;
            1:       r[30:0] = 31'h7F800000;
            2:       begin r[30:23] = 8'hFF; if (r[22:0] == 23'd0) r[0] = 1'b1; end
            3, 4:    r[30:23] = 8'h00;
            default: if (r[30:23] == 8'h00 || r[30:23] == 8'hFF) r[30:23] = 8'h7F;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(1, 254));
        return r;
    endfunction

    // Monitor: freeze check on en=0 edges, scoreboard pops on en=1 edges.
    initial begin : monitor
        logic [95:0] snap;
        logic        en_s;
        exp_t        e;
        forever begin
            @(posedge clk);
            en_s = en;
            snap = outs();
            if (rst_n && en) en_edges++;
            #1;
            if (rst_n) begin
                if (!en_s) begin
                    check("stall_freeze", outs(), snap);
                    check("stall_in_rdy", 96'(io.in_rdy), 96'(0));
                end else begin
                    if (io.div_vld) begin
                        if (issue_q.size() == 0) begin
                            check("div_vld_unexpected", 96'(io.div_vld), 96'(0));
                        end else begin
                            e = issue_q.pop_front();
                            check("issue_edge", 96'(en_edges), 96'(e.edge_n));
                            check("div_ain", 96'(io.div_ain), 96'(e.ain));
                            check("div_bin", 96'(io.div_bin), 96'(e.bin));
                        end
                    end
                    if (io.sb_vld) begin
                        if (sb_q.size() == 0) begin
                            check("sb_vld_unexpected", 96'(io.sb_vld), 96'(0));
                        end else begin
                            e = sb_q.pop_front();
                            check("sb_edge", 96'(en_edges), 96'(e.edge_n));
                            check("sb_sign", 96'(io.sb_sign), 96'(e.sign));
                            check("sb_cls", 96'(io.sb_cls), 96'(e.cls));
                            check("sb_dz", 96'(io.sb_dz), 96'(e.dz));
                            if (e.cls == 2'd0) check("sb_exp", 96'(io.sb_exp), 96'(e.exp));
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input exp_t e);
        int   guard;
        exp_t s;
        @(negedge clk);
        en = 1'b1; io.in_vld = 1'b1; io.a = x; io.b = y;
        #1;
        guard = 0;
        while (!io.in_rdy && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        check("accept_rdy", 96'(io.in_rdy), 96'(1));
        if (io.in_rdy) begin
            e.edge_n = en_edges + 1 + e.off;
            s = e;
            s.edge_n = e.edge_n + DIV_LAT;
            issue_q.push_back(e);
            sb_q.push_back(s);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b1; io.in_vld = 1'b0;
        end
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0; io.in_vld = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; io.in_vld = 1'b0;
        #1;
        check("reset_outputs", outs(), 96'(0));
        issue_q.delete();
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_rdy", 96'(io.in_rdy), 96'(1));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : driver
        logic [31:0] x, y;
        io.in_vld = 1'b0; io.a = '0; io.b = '0;
        #2;
        check("reset_state", outs(), 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1; en = 1'b1;

        // Directed vectors with hand-derived expectations.
        send(32'h40C00000, 32'h40000000, mk(48'hC00000000000, 24'h800000, 1'b0, 10'd128, 2'd0, 1'b0, 0));
        send(32'h3F800000, 32'h00000000, mk(48'h0, 24'h800000, 1'b0, 10'd0, 2'd2, 1'b1, 0));
        send(32'h00000000, 32'h00000000, mk(48'h0, 24'h800000, 1'b0, 10'd0, 2'd3, 1'b0, 0));
        send(32'h7F800000, 32'hFF800000, mk(48'h0, 24'h800000, 1'b1, 10'd0, 2'd3, 1'b0, 0));
        send(32'hBF800000, 32'h7F800000, mk(48'h0, 24'h800000, 1'b1, 10'd0, 2'd1, 1'b0, 0));
`ifdef FP_DIV_SUBNORM_EN
        send(32'h00000001, 32'h3F800000, mk(48'h800000000000, 24'h800000, 1'b0, 10'h3EA, 2'd0, 1'b0, 24));
`else
        send(32'h00000001, 32'h3F800000, mk(48'h0, 24'h800000, 1'b0, 10'd0, 2'd1, 1'b0, 0));
`endif
        idle(DIV_LAT + 4);

        // Back-to-back stream with a 3-cycle en=0 hold in the middle.
        for (int i = 0; i < 4; i++) begin
            x = rand_normal(); y = rand_normal();
            send(x, y, model(x, y));
        end
        stall(3);
        for (int i = 0; i < 2; i++) begin
            x = rand_normal(); y = rand_normal();
            send(x, y, model(x, y));
        end
        idle(DIV_LAT + 4);

        // Random mix of classes, gaps and stalls.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       stall($urandom_range(1, 3));
                1:       idle($urandom_range(1, 2));
                default: ;
            endcase
            x = rand_op(); y = rand_op();
            send(x, y, model(x, y));
        end
        idle(2);

        // Reset with work in flight; nothing may emerge afterwards.
`ifdef FP_DIV_SUBNORM_EN
        send(32'h00000001, 32'h3F800000, model(32'h00000001, 32'h3F800000));
        idle(5);
`else
        send(32'h3F800000, 32'h40000000, model(32'h3F800000, 32'h40000000));
`endif
        do_reset();
        idle(DIV_LAT + 6);
        send(32'h40C00000, 32'h40000000, mk(48'hC00000000000, 24'h800000, 1'b0, 10'd128, 2'd0, 1'b0, 0));
        idle(1);

        for (int i = 0; i < 300 && (issue_q.size() != 0 || sb_q.size() != 0); i++) idle(1);
        check("drain_issue_q", 96'(issue_q.size()), 96'(0));
        check("drain_sb_q", 96'(sb_q.size()), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
